// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LMU = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; grants are combinational, pointer updates on grant.
// On contention the index that did not win last time is granted, so neither side waits more than one cycle.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_valid0,
  input  logic i_valid1,
  output logic o_gnt0,
  output logic o_gnt1,
  output logic o_gnt_idx
);

  logic r_last;
  logic w_gnt0;
  logic w_gnt1;

  assign w_gnt0    = i_valid0 & (~i_valid1 | (r_last == REQ_LMU));
  assign w_gnt1    = i_valid1 & (~i_valid0 | (r_last == REQ_ALU));
  assign o_gnt0    = w_gnt0;
  assign o_gnt1    = w_gnt1;
  assign o_gnt_idx = w_gnt1 ? REQ_LMU : REQ_ALU;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= REQ_LMU;
    end else if (w_gnt0 | w_gnt1) begin
      r_last <= w_gnt1 ? REQ_LMU : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load/mul writeback; 1-cycle registered write stage.
// Readies are the arbiter grants; the write stage never stalls. Busy scoreboard clears on write.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_data,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_addr,
  input  logic [AW-1:0]   chk_addr1,
  input  logic [AW-1:0]   chk_addr2,
  output logic            chk_busy1,
  output logic            chk_busy2,
  output logic [AW-1:0]   rf_a3,
  output logic [DW-1:0]   rf_wd3,
  output logic            rf_we3,
  output logic [NREG-1:0] busy_vec
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_gnt_idx;
  logic            w_gnt;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  logic            r_we3;
  logic [AW-1:0]   r_a3;
  logic [DW-1:0]   r_wd3;
  logic [NREG-1:0] r_busy;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_valid0  (req0_valid),
    .i_valid1  (req1_valid),
    .o_gnt0    (w_gnt0),
    .o_gnt1    (w_gnt1),
    .o_gnt_idx (w_gnt_idx)
  );

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_gnt      = w_gnt0 | w_gnt1;
  assign w_addr     = (w_gnt_idx == REQ_LMU) ? req1_addr : req0_addr;
  assign w_data     = (w_gnt_idx == REQ_LMU) ? req1_data : req0_data;

  // x0 writes complete the handshake but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (w_gnt && (w_addr != REG_ZERO)) begin
      r_we3 <= 1'b1;
      r_a3  <= w_addr;
      r_wd3 <= w_data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  // Set is applied after clear so a fresh reservation survives a same-edge commit.
  assign w_set = (rsv_valid && (rsv_addr != REG_ZERO)) ? (ONE << rsv_addr) : '0;
  assign w_clr = r_we3 ? (ONE << r_a3) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign rf_we3    = r_we3;
  assign rf_a3     = r_a3;
  assign rf_wd3    = r_wd3;
  assign busy_vec  = r_busy;
  assign chk_busy1 = r_busy[chk_addr1];
  assign chk_busy2 = r_busy[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [4:0]  chk_addr1, chk_addr2;
  logic        chk_busy1, chk_busy2;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we3;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .chk_addr1  (chk_addr1),
    .chk_addr2  (chk_addr2),
    .chk_busy1  (chk_busy1),
    .chk_busy2  (chk_busy2),
    .rf_a3      (rf_a3),
    .rf_wd3     (rf_wd3),
    .rf_we3     (rf_we3),
    .busy_vec   (busy_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    chk_addr1 = '0; chk_addr2 = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_we3",  {31'd0, rf_we3}, 32'd0);
    check("rst_a3",   {27'd0, rf_a3},  32'd0);
    check("rst_wd3",  rf_wd3,          32'd0);
    check("rst_busy", busy_vec,        32'd0);

    // Single write: reserve 3, then commit 3.
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_valid = 1'b0;
    chk_addr1 = 5'd3;
    #1;
    check("sw_busy_set", busy_vec, 32'h0000_0008);
    check("sw_chk1_busy", {31'd0, chk_busy1}, 32'd1);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1234_5678;
    #1;
    check("sw_rdy0", {31'd0, req0_ready}, 32'd1);
    check("sw_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    check("sw_we3", {31'd0, rf_we3}, 32'd1);
    check("sw_a3",  {27'd0, rf_a3},  32'd3);
    check("sw_wd3", rf_wd3, 32'h1234_5678);
    check("sw_busy_inflight", {31'd0, chk_busy1}, 32'd1);
    tick();
    check("sw_we3_off", {31'd0, rf_we3}, 32'd0);
    check("sw_a3_hold", {27'd0, rf_a3},  32'd3);
    check("sw_busy_clr", busy_vec, 32'd0);
    check("sw_chk1_free", {31'd0, chk_busy1}, 32'd0);

    // Reset mid-write: staged write to 5 is dropped.
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_00AA;
    tick();
    rsv_valid = 1'b0; req0_valid = 1'b0;
    check("rmw_staged", {31'd0, rf_we3}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmw_we3",  {31'd0, rf_we3}, 32'd0);
    check("rmw_a3",   {27'd0, rf_a3},  32'd0);
    check("rmw_wd3",  rf_wd3, 32'd0);
    check("rmw_busy", busy_vec, 32'd0);

    // Contention after reset: req0 first (last=1), then alternate.
    req0_valid = 1'b1; req0_addr = 5'd11; req0_data = 32'hA0A0_0011;
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'hB0B0_0012;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("ct_rdy0_%0d", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("ct_rdy1_%0d", i), {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check($sformatf("ct_we3_%0d", i), {31'd0, rf_we3}, 32'd1);
      check($sformatf("ct_a3_%0d", i), {27'd0, rf_a3}, (i % 2 == 0) ? 32'd11 : 32'd12);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // x0 write and x0 reservation.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    #1;
    check("x0_rdy1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0; rsv_valid = 1'b0;
    check("x0_we3",   {31'd0, rf_we3}, 32'd0);
    check("x0_wd3_hold", rf_wd3, 32'hB0B0_0012);
    check("x0_busy",  busy_vec, 32'd0);
    check("x0_chk1",  {31'd0, chk_busy1}, 32'd0);
    check("x0_chk2",  {31'd0, chk_busy2}, 32'd0);

    // Set/clear collision on 7: set wins.
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
    tick();
    req0_valid = 1'b0;
    check("col_we3", {31'd0, rf_we3}, 32'd1);
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    chk_addr2 = 5'd7;
    #1;
    check("col_busy7", busy_vec, 32'h0000_0080);
    check("col_chk2",  {31'd0, chk_busy2}, 32'd1);

    // Set 9 while 7 commits: both apply.
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0177;
    tick();
    req0_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_valid = 1'b0;
    check("dif_busy", busy_vec, 32'h0000_0200);

    // Back-to-back req1 to 8,9,10.
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1; req1_addr = 5'(8 + i); req1_data = 32'hC000_0000 + i;
      #1;
      check($sformatf("bb_rdy1_%0d", i), {31'd0, req1_ready}, 32'd1);
      tick();
      check($sformatf("bb_we3_%0d", i), {31'd0, rf_we3}, 32'd1);
      check($sformatf("bb_a3_%0d", i), {27'd0, rf_a3}, 32'(8 + i));
      check($sformatf("bb_wd3_%0d", i), rf_wd3, 32'hC000_0000 + i);
    end
    req1_valid = 1'b0;
    tick();
    check("bb_we3_off", {31'd0, rf_we3}, 32'd0);
    check("bb_busy", busy_vec, 32'd0);

    // Same address from both: last=1 so req0 first, req1's data lands last.
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h0000_AAAA;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_BBBB;
    tick();
    req0_valid = 1'b0;
    check("sa_wd3_0", rf_wd3, 32'h0000_AAAA);
    #1;
    check("sa_rdy1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    check("sa_wd3_1", rf_wd3, 32'h0000_BBBB);
    check("sa_a3_1", {27'd0, rf_a3}, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (A3/WD3/WE3) of the 32x32 register file and shares it between two writeback requesters: req0 = ALU pipe, req1 = multi-cycle load/mul unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write stage.
- 32-bit busy scoreboard: the issue stage reserves a destination register, and the busy bit is cleared when its write lands.
- Sits between the execute/memory units and the register file; issue logic queries busy bits for its two source registers.

Parameters:
- AW, 5, register address width.
- DW, 32, data width.
- NREG, 32, number of registers; must equal 2**AW.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  ALU writeback request
- req0_ready  output  1  req0 granted this cycle
- req0_addr  input  AW  destination register
- req0_data  input  DW  write data
- req1_valid  input  1  load/mul writeback request
- req1_ready  output  1  req1 granted this cycle
- req1_addr  input  AW  destination register
- req1_data  input  DW  write data
- rsv_valid  input  1  issue stage reserves rsv_addr
- rsv_addr  input  AW  register to mark busy
- chk_addr1  input  AW  source register 1 to query
- chk_addr2  input  AW  source register 2 to query
- chk_busy1  output  1  chk_addr1 has a pending write
- chk_busy2  output  1  chk_addr2 has a pending write
- rf_a3  output  AW  register file write address
- rf_wd3  output  DW  register file write data
- rf_we3  output  1  register file write enable
- busy_vec  output  NREG  scoreboard bits, bit 0 always 0

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - rf_we3=0, rf_a3=0, rf_wd3=0.
  - busy_vec=0.
  - Round-robin pointer last=1, so req0 wins the first contention.
  - An in-flight write staged in the output register is dropped; the register file is not written.
- Handshake:
  - reqN_ready is combinational from the valids and the pointer. It never depends on reqN_ready of the other port.
  - A transfer completes in the cycle where valid & ready are both high.
  - The requester must hold addr/data stable while valid is high and ready is low.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: grant the index != last.
  - last is updated to the granted index on every grant and holds when there is no grant.
  - Starvation bound: 1 cycle.
- Write stage latency 1:
  - A grant in cycle N loads rf_a3/rf_wd3, with rf_we3=1, for cycle N+1.
  - The register file captures the write at the rising edge ending cycle N+1.
  - With no grant, rf_we3=0 next cycle; rf_a3/rf_wd3 hold their previous values.
  - The stage never stalls: one write per cycle sustained.
- x0:
  - A granted request with addr=0 completes its handshake.
  - rf_we3 stays 0 for it and the scoreboard is untouched.
  - A reservation of addr 0 is ignored.
  - chk_busyN=0 for chk_addrN=0.
- Scoreboard:
  - A reservation (rsv_valid with rsv_addr!=0) sets busy[rsv_addr] at the edge.
  - busy[rf_a3] clears at the edge ending the cycle where rf_we3=1, i.e. the same edge the data is written.
  - chk_busyN = busy_vec[chk_addrN], combinational.
  - A consumer may therefore read fresh data from cycle N+2 onward.
- Simultaneous events:
  - Set and clear of the same address at the same edge: set wins, so the bit stays 1 for the newer reservation.
  - Set and clear of different addresses: both apply.
  - Both requesters targeting the same address: both are serviced in round-robin order; the later grant's data persists.
  - Reserving an already-busy register leaves it busy. There is no count; the first commit clears it. Issue logic must stall on WAW, and this is a documented constraint, not checked.
- Commit without reservation: the write proceeds; clearing an already-0 bit is harmless.

Decomposition:
- Package regfile_pkg holds:
  - AW/DW/NREG defaults.
  - Constant REG_ZERO=0.
  - Requester index constants REQ_ALU=0, REQ_LMU=1.
- One sub-module, rr_arb2: a two-input round-robin arbiter with its own last pointer and reset.
- Scoreboard and write stage stay inline.

Test Plan:
- Reset mid-write:
  - Stimulus: grant req0 (addr=5, data=0xAA) in cycle N; assert reset in cycle N+1.
  - Response: after reset, rf_we3=0, busy_vec=0, last=1.
- Single write:
  - Stimulus: rsv addr=3, then req0 (addr=3, data=0x12345678).
  - Response: req0_ready=1 the same cycle; next cycle rf_we3=1, rf_a3=3, rf_wd3=0x12345678; busy[3] goes 1 to 0 at that edge; chk_busy1(3)=0 afterwards.
- Contention:
  - Stimulus: req0 and req1 both held valid for 4 cycles after reset.
  - Response: grant order 0,1,0,1; rf_a3 sequence matches; each ready pulses once per 2 cycles.
- x0 write:
  - Stimulus: req1 (addr=0, data=0xFFFFFFFF), plus rsv addr=0.
  - Response: req1_ready=1, rf_we3 stays 0, busy_vec stays 0, chk_busy for addr 0 = 0.
- Set/clear collision:
  - Stimulus: busy[7]=1 with a commit to 7 in flight, and rsv addr=7 in the same cycle as rf_we3=1 to 7.
  - Response: busy[7]=1 after the edge.
- Back-to-back single requester:
  - Stimulus: req1 valid for 3 cycles with addrs 8,9,10.
  - Response: ready=1 every cycle; rf_we3 high for 3 consecutive cycles with rf_a3 8,9,10.
